// File: rtl/pdp8_pkg.sv
// Shared PDP-8 widths, reset vector and memory-arbiter types.
package pdp8_pkg;

  localparam int ADDR_WIDTH     = 12;
  localparam int DATA_WIDTH     = 12;
  localparam logic [ADDR_WIDTH-1:0] START_ADDRESS = 12'o0200;
  localparam int MEM_RD_LATENCY = 1;
  localparam int STARVE_CNT_W   = 4;

  typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_RESP} arb_state_e;
  typedef enum logic {OWN_IFU, OWN_EXU} arb_owner_e;

endpackage

// File: rtl/pdp8_arb_prio.sv
// Priority select between IFU and EXU: EXU is preferred, but an IFU that has
// lost STARVE_LIMIT arbitrations in a row is forced to win the next one.
module pdp8_arb_prio
  import pdp8_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    arb_en_i,
  input  logic                    ifu_req_i,
  input  logic                    exu_req_i,
  output logic                    ifu_win_o,
  output logic                    exu_win_o,
  output logic [STARVE_CNT_W-1:0] starve_cnt_o
);

  logic [STARVE_CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic                    force_ifu;

  always_comb begin
    force_ifu    = (starve_cnt_q == STARVE_CNT_W'(STARVE_LIMIT));
    ifu_win_o    = arb_en_i && ifu_req_i && (!exu_req_i || force_ifu);
    exu_win_o    = arb_en_i && exu_req_i && !ifu_win_o;
    starve_cnt_d = starve_cnt_q;
    // Only a real loss counts: IFU asking in IDLE while EXU takes the port.
    if (ifu_win_o) begin
      starve_cnt_d = '0;
    end else if (exu_win_o && ifu_req_i && !force_ifu) begin
      starve_cnt_d = starve_cnt_q + STARVE_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign starve_cnt_o = starve_cnt_q;

endmodule

// File: rtl/pdp8_mem_arbiter.sv
// Single-port PDP-8 memory sequencer shared by IFU and EXU: one transaction at
// a time, fixed read latency, read data routed back to the owning requester.
module pdp8_mem_arbiter
  import pdp8_pkg::*;
#(
  parameter int ADDR_W       = ADDR_WIDTH,
  parameter int DATA_W       = DATA_WIDTH,
  parameter int RD_LATENCY   = MEM_RD_LATENCY,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    ifu_rd_req,
  input  logic [ADDR_W-1:0]       ifu_rd_addr,
  output logic                    ifu_gnt,
  output logic                    ifu_rd_valid,
  output logic [DATA_W-1:0]       ifu_rd_data,
  input  logic                    exu_req,
  input  logic                    exu_we,
  input  logic [ADDR_W-1:0]       exu_addr,
  input  logic [DATA_W-1:0]       exu_wdata,
  output logic                    exu_gnt,
  output logic                    exu_rd_valid,
  output logic [DATA_W-1:0]       exu_rd_data,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [DATA_W-1:0]       mem_wdata,
  input  logic [DATA_W-1:0]       mem_rdata,
  output logic                    busy,
  output arb_state_e              dbg_state_o,
  output logic [STARVE_CNT_W-1:0] dbg_starve_cnt_o
);

  // Handshake: a requester holds req (and its address/data) until its gnt
  // pulse; gnt is given combinationally in IDLE, and a req still high in the
  // following cycle is a new request. rd_valid is a one-cycle pulse and
  // rd_data holds its value until that requester's next read completes.

  localparam logic [2:0] LAT_LOAD = 3'(RD_LATENCY - 1);

  arb_state_e          state_q, state_d;
  arb_owner_e          owner_q, owner_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [2:0]          lat_q, lat_d;
  logic [DATA_W-1:0]   ifu_data_q, ifu_data_d, exu_data_q, exu_data_d;
  logic                ifu_valid_q, ifu_valid_d, exu_valid_q, exu_valid_d;
  logic                arb_en, ifu_win, exu_win;

  // Reset is folded in so no grant can leak out while reset is held.
  assign arb_en = (state_q == ARB_IDLE) && !reset_n;

  pdp8_arb_prio #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_prio (
    .clk          (clk),
    .reset_n      (reset_n),
    .arb_en_i     (arb_en),
    .ifu_req_i    (ifu_rd_req),
    .exu_req_i    (exu_req),
    .ifu_win_o    (ifu_win),
    .exu_win_o    (exu_win),
    .starve_cnt_o (dbg_starve_cnt_o)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    lat_d       = lat_q;
    ifu_data_d  = ifu_data_q;
    exu_data_d  = exu_data_q;
    ifu_valid_d = 1'b0;
    exu_valid_d = 1'b0;
    ifu_gnt     = 1'b0;
    exu_gnt     = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    case (state_q)
      ARB_IDLE: begin
        if (ifu_win) begin
          owner_d = OWN_IFU;
          we_d    = 1'b0;
          addr_d  = ifu_rd_addr;
          wdata_d = '0;
          ifu_gnt = 1'b1;
          state_d = ARB_ISSUE;
        end else if (exu_win) begin
          owner_d = OWN_EXU;
          we_d    = exu_we;
          addr_d  = exu_addr;
          wdata_d = exu_wdata;
          exu_gnt = 1'b1;
          state_d = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        mem_req   = 1'b1;
        mem_we    = we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        if (we_q) begin
          state_d = ARB_IDLE;
        end else begin
          lat_d   = LAT_LOAD;
          state_d = (RD_LATENCY == 1) ? ARB_RESP : ARB_WAIT;
        end
      end
      ARB_WAIT: begin
        lat_d = lat_q - 3'd1;
        if (lat_q == 3'd1) begin
          state_d = ARB_RESP;
        end
      end
      ARB_RESP: begin
        if (owner_q == OWN_IFU) begin
          ifu_data_d  = mem_rdata;
          ifu_valid_d = 1'b1;
        end else begin
          exu_data_d  = mem_rdata;
          exu_valid_d = 1'b1;
        end
        state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      state_q     <= ARB_IDLE;
      owner_q     <= OWN_IFU;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      lat_q       <= '0;
      ifu_data_q  <= '0;
      exu_data_q  <= '0;
      ifu_valid_q <= 1'b0;
      exu_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      lat_q       <= lat_d;
      ifu_data_q  <= ifu_data_d;
      exu_data_q  <= exu_data_d;
      ifu_valid_q <= ifu_valid_d;
      exu_valid_q <= exu_valid_d;
    end
  end

  assign ifu_rd_valid = ifu_valid_q;
  assign ifu_rd_data  = ifu_data_q;
  assign exu_rd_valid = exu_valid_q;
  assign exu_rd_data  = exu_data_q;
  assign busy         = (state_q != ARB_IDLE);
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_pdp8_mem_arbiter.sv
// Bench for pdp8_mem_arbiter: main instance at read latency 3 plus three
// single-read lanes at latencies 1, 2 and 7.
module tb_pdp8_mem_arbiter;
  import pdp8_pkg::*;

  localparam int ML = 3;
  localparam int SL = 4;
  localparam logic [11:0] JUNK = 12'o5555;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  bit lane_go = 1'b0;
  int starve_tab [6] = '{1, 2, 3, 4, 0, 1};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0o required=%0o", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input string detail);
    checks++;
    errors++;
    $display("FAIL %s %s", name, detail);
  endtask

  // ---------------- main DUT ----------------
  logic        ifu_rd_req, ifu_gnt, ifu_rd_valid;
  logic [11:0] ifu_rd_addr, ifu_rd_data;
  logic        exu_req, exu_we, exu_gnt, exu_rd_valid;
  logic [11:0] exu_addr, exu_wdata, exu_rd_data;
  logic        mem_req, mem_we, busy;
  logic [11:0] mem_addr, mem_wdata, mem_rdata;
  arb_state_e  dbg_state;
  logic [3:0]  dbg_starve_cnt;

  pdp8_mem_arbiter #(.ADDR_W(12), .DATA_W(12), .RD_LATENCY(ML), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .reset_n(reset_n),
    .ifu_rd_req(ifu_rd_req), .ifu_rd_addr(ifu_rd_addr), .ifu_gnt(ifu_gnt),
    .ifu_rd_valid(ifu_rd_valid), .ifu_rd_data(ifu_rd_data),
    .exu_req(exu_req), .exu_we(exu_we), .exu_addr(exu_addr), .exu_wdata(exu_wdata),
    .exu_gnt(exu_gnt), .exu_rd_valid(exu_rd_valid), .exu_rd_data(exu_rd_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy),
    .dbg_state_o(dbg_state), .dbg_starve_cnt_o(dbg_starve_cnt)
  );

  // memory model: data appears for exactly the ML-th cycle after the command
  logic [11:0] mem [0:4095];
  int          rd_cnt = 0;
  logic [11:0] rd_addr = '0;
  always @(negedge clk) begin
    if (rd_cnt > 0) begin
      rd_cnt--;
      mem_rdata = (rd_cnt == 0) ? mem[rd_addr] : JUNK;
    end else begin
      mem_rdata = JUNK;
    end
    if (mem_req) begin
      if (mem_we) mem[mem_addr] = mem_wdata;
      else begin
        rd_addr = mem_addr;
        rd_cnt  = ML;
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [0:0]  gnt_exp_q[$];   // 0 = IFU, 1 = EXU
  logic [24:0] mem_exp_q[$];   // {we, addr, wdata (writes only)}
  logic [11:0] ifu_exp_q[$];
  logic [11:0] exu_exp_q[$];
  int last_gnt_cyc = 0, ifu_gnt_cyc = 0, exu_gnt_cyc = 0;

  always @(negedge clk) begin
    if (!reset_n) begin
      if (ifu_rd_valid) begin
        if (ifu_exp_q.size() == 0) fail("ifu_unexpected_valid", $sformatf("data=%0o", ifu_rd_data));
        else begin
          check("ifu_rd_latency", cyc - ifu_gnt_cyc, ML + 2);
          check("ifu_rd_data", ifu_rd_data, ifu_exp_q.pop_front());
        end
      end
      if (exu_rd_valid) begin
        if (exu_exp_q.size() == 0) fail("exu_unexpected_valid", $sformatf("data=%0o", exu_rd_data));
        else begin
          check("exu_rd_latency", cyc - exu_gnt_cyc, ML + 2);
          check("exu_rd_data", exu_rd_data, exu_exp_q.pop_front());
        end
      end
      if (mem_req) begin
        check("mem_req_after_gnt", cyc - last_gnt_cyc, 1);
        if (mem_exp_q.size() == 0) fail("mem_unexpected_cmd", $sformatf("addr=%0o", mem_addr));
        else check("mem_cmd", {mem_we, mem_addr, mem_we ? mem_wdata : 12'o0}, mem_exp_q.pop_front());
      end else begin
        check("mem_quiet", {mem_we, mem_addr, mem_wdata}, 25'd0);
      end
      if (ifu_gnt && exu_gnt) fail("double_grant", "both gnt high");
      else if (ifu_gnt || exu_gnt) begin
        if (gnt_exp_q.size() == 0) fail("unexpected_grant", $sformatf("exu_gnt=%0d", exu_gnt));
        else check("grant_owner", exu_gnt, gnt_exp_q.pop_front());
        last_gnt_cyc = cyc;
        if (ifu_gnt) ifu_gnt_cyc = cyc;
        else exu_gnt_cyc = cyc;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_gnt(input bit want_ifu, input bit want_exu, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if ((want_ifu && ifu_gnt) || (want_exu && exu_gnt)) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail("gnt_timeout", "no grant within 40 cycles");
  endtask

  task automatic drain();
    int n = 0;
    while ((gnt_exp_q.size() + mem_exp_q.size() + ifu_exp_q.size() + exu_exp_q.size()) != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if ((gnt_exp_q.size() + mem_exp_q.size() + ifu_exp_q.size() + exu_exp_q.size()) != 0) begin
      fail("drain_timeout", $sformatf("pending gnt=%0d mem=%0d ifu=%0d exu=%0d", gnt_exp_q.size(),
           mem_exp_q.size(), ifu_exp_q.size(), exu_exp_q.size()));
      gnt_exp_q.delete(); mem_exp_q.delete(); ifu_exp_q.delete(); exu_exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic ifu_read(input logic [11:0] addr, input logic [11:0] exp);
    bit ok;
    gnt_exp_q.push_back(1'b0);
    mem_exp_q.push_back({1'b0, addr, 12'o0});
    ifu_exp_q.push_back(exp);
    @(posedge clk); #1;
    ifu_rd_req = 1'b1; ifu_rd_addr = addr;
    wait_gnt(1'b1, 1'b0, ok);
    @(posedge clk); #1;
    ifu_rd_req = 1'b0;
    drain();
  endtask

  task automatic exu_op(input logic we, input logic [11:0] addr, input logic [11:0] wdata,
                        input logic [11:0] exp);
    bit ok;
    gnt_exp_q.push_back(1'b1);
    mem_exp_q.push_back({we, addr, we ? wdata : 12'o0});
    if (!we) exu_exp_q.push_back(exp);
    @(posedge clk); #1;
    exu_req = 1'b1; exu_we = we; exu_addr = addr; exu_wdata = wdata;
    wait_gnt(1'b0, 1'b1, ok);
    @(posedge clk); #1;
    exu_req = 1'b0;
    drain();
  endtask

  // ---------------- latency-sweep lanes ----------------
  for (genvar li = 0; li < 3; li++) begin : g_lane
    localparam int LL = (li == 0) ? 1 : ((li == 1) ? 2 : 7);
    logic        l_req = 1'b0, l_gnt, l_vld, l_exu_gnt, l_exu_vld, l_mem_req, l_mem_we, l_busy;
    logic [11:0] l_addr = '0, l_data, l_exu_data, l_mem_addr, l_mem_wdata;
    logic [11:0] l_mem_rdata = 12'o5555;
    arb_state_e  l_state;
    logic [3:0]  l_starve;
    int          l_cnt = 0;
    logic [11:0] l_raddr = '0;
    logic [11:0] l_exp_q[$];
    int          l_gnt_cyc = 0;
    bit          done = 1'b0;

    pdp8_mem_arbiter #(.ADDR_W(12), .DATA_W(12), .RD_LATENCY(LL), .STARVE_LIMIT(SL)) u_lane (
      .clk(clk), .reset_n(reset_n),
      .ifu_rd_req(l_req), .ifu_rd_addr(l_addr), .ifu_gnt(l_gnt),
      .ifu_rd_valid(l_vld), .ifu_rd_data(l_data),
      .exu_req(1'b0), .exu_we(1'b0), .exu_addr(12'o0), .exu_wdata(12'o0),
      .exu_gnt(l_exu_gnt), .exu_rd_valid(l_exu_vld), .exu_rd_data(l_exu_data),
      .mem_req(l_mem_req), .mem_we(l_mem_we), .mem_addr(l_mem_addr), .mem_wdata(l_mem_wdata),
      .mem_rdata(l_mem_rdata), .busy(l_busy),
      .dbg_state_o(l_state), .dbg_starve_cnt_o(l_starve)
    );

    always @(negedge clk) begin
      if (l_cnt > 0) begin
        l_cnt--;
        l_mem_rdata = (l_cnt == 0 && l_raddr == 12'o0200) ? 12'o7402 : JUNK;
      end else begin
        l_mem_rdata = JUNK;
      end
      if (l_mem_req && !l_mem_we) begin
        l_raddr = l_mem_addr;
        l_cnt   = LL;
      end
    end

    always @(negedge clk) begin
      if (!reset_n) begin
        if (l_vld) begin
          if (l_exp_q.size() == 0) fail($sformatf("lane%0d_unexpected_valid", LL), $sformatf("data=%0o", l_data));
          else begin
            check($sformatf("lane%0d_latency", LL), cyc - l_gnt_cyc, LL + 2);
            check($sformatf("lane%0d_data", LL), l_data, l_exp_q.pop_front());
          end
        end
        if (l_gnt) l_gnt_cyc = cyc;
      end
    end

    initial begin
      bit ok;
      wait (lane_go);
      l_exp_q.push_back(12'o7402);
      @(posedge clk); #1;
      l_req = 1'b1; l_addr = 12'o0200;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (l_gnt) begin
          ok = 1'b1;
          break;
        end
      end
      if (!ok) fail($sformatf("lane%0d_gnt_timeout", LL), "no grant");
      @(posedge clk); #1;
      l_req = 1'b0;
      for (int i = 0; i < 20 && l_exp_q.size() != 0; i++) @(negedge clk);
      if (l_exp_q.size() != 0) begin
        fail($sformatf("lane%0d_valid_timeout", LL), "no rd_valid");
        l_exp_q.delete();
      end
      done = 1'b1;
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    bit ok;
    int n;
    for (int i = 0; i < 4096; i++) mem[i] = JUNK;
    mem[12'o0200] = 12'o7402;
    mem[12'o0201] = 12'o1111;
    ifu_rd_req = 1'b1; ifu_rd_addr = 12'o0200;
    exu_req = 1'b1; exu_we = 1'b0; exu_addr = 12'o0050; exu_wdata = 12'o0;

    // requests held during reset must be ignored
    repeat (3) @(posedge clk);
    #2;
    check("rst_ifu_gnt", ifu_gnt, 1'b0);
    check("rst_exu_gnt", exu_gnt, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_state", dbg_state, ARB_IDLE);
    check("rst_outputs", {ifu_rd_valid, exu_rd_valid, mem_req, ifu_rd_data, exu_rd_data}, 27'd0);
    ifu_rd_req = 1'b0; exu_req = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b0;

    // IFU read, then EXU write/read of the same word
    ifu_read(12'o0200, 12'o7402);
    exu_op(1'b1, 12'o0050, 12'o1234, 12'o0);
    exu_op(1'b0, 12'o0050, 12'o0, 12'o1234);
    check("ifu_data_kept", ifu_rd_data, 12'o7402);
    check("exu_data_held", exu_rd_data, 12'o1234);

    // contention: EXU x4, forced IFU, EXU
    for (int g = 0; g < 4; g++) begin
      gnt_exp_q.push_back(1'b1); mem_exp_q.push_back({1'b1, 12'o0400, 12'o0001});
    end
    gnt_exp_q.push_back(1'b0); mem_exp_q.push_back({1'b0, 12'o0200, 12'o0});
    ifu_exp_q.push_back(12'o7402);
    gnt_exp_q.push_back(1'b1); mem_exp_q.push_back({1'b1, 12'o0400, 12'o0001});
    @(posedge clk); #1;
    ifu_rd_req = 1'b1; ifu_rd_addr = 12'o0200;
    exu_req = 1'b1; exu_we = 1'b1; exu_addr = 12'o0400; exu_wdata = 12'o0001;
    for (int g = 0; g < 6; g++) begin
      wait_gnt(1'b1, 1'b1, ok);
      @(posedge clk); #1;
      check($sformatf("starve_cnt_after_gnt%0d", g), dbg_starve_cnt, starve_tab[g]);
    end
    ifu_rd_req = 1'b0; exu_req = 1'b0;
    drain();

    // IFU request raised and dropped while EXU read is in flight
    gnt_exp_q.push_back(1'b1); mem_exp_q.push_back({1'b0, 12'o0050, 12'o0});
    exu_exp_q.push_back(12'o1234);
    @(posedge clk); #1;
    exu_req = 1'b1; exu_we = 1'b0; exu_addr = 12'o0050; exu_wdata = 12'o0;
    wait_gnt(1'b0, 1'b1, ok);
    @(posedge clk); #1;
    exu_req = 1'b0; ifu_rd_req = 1'b1; ifu_rd_addr = 12'o0201;
    repeat (2) @(posedge clk);
    #1;
    ifu_rd_req = 1'b0;
    drain();
    check("starve_unchanged", dbg_starve_cnt, 4'd1);

    // reset while the read sits in WAIT
    gnt_exp_q.push_back(1'b0); mem_exp_q.push_back({1'b0, 12'o0201, 12'o0});
    @(posedge clk); #1;
    ifu_rd_req = 1'b1; ifu_rd_addr = 12'o0201;
    wait_gnt(1'b1, 1'b0, ok);
    @(posedge clk); #1;
    ifu_rd_req = 1'b0;
    @(posedge clk); #3;
    reset_n = 1'b1;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_state", dbg_state, ARB_IDLE);
    check("midrst_starve", dbg_starve_cnt, 4'd0);
    check("midrst_outputs", {ifu_rd_valid, exu_rd_valid, mem_req, ifu_rd_data, exu_rd_data}, 27'd0);
    check("midrst_cmd_seen", mem_exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b0;
    gnt_exp_q.delete();
    repeat (8) @(negedge clk);
    ifu_read(12'o0201, 12'o1111);

    // latency sweep lanes
    lane_go = 1'b1;
    n = 0;
    while (!(g_lane[0].done && g_lane[1].done && g_lane[2].done) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!(g_lane[0].done && g_lane[1].done && g_lane[2].done)) fail("lane_timeout", "lanes not done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout sim time limit reached");
    $fatal(1, "timeout");
  end

endmodule
